// File: rtl/cdr_pkg.sv
// cdr_pkg
// Shared definitions for the phase-shift control loop:
//   TAP_W       - width of the delay-line tap index
//   NUM_TAPS    - number of taps in the delay line (index wraps modulo this)
//   cdr_state_t - loop controller FSM state encoding
package cdr_pkg;

   localparam int TAP_W    = 4;
   localparam int NUM_TAPS = 16;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_TRACK   = 2'd1,
      ST_HOLDOFF = 2'd2
   } cdr_state_t;

endpackage

// File: rtl/cdr_vote_acc.sv
// cdr_vote_acc
// Signed vote accumulator for the phase detector. Decodes up/dn votes into
// +1 / -1 / 0, and flags when the next value would reach +THRESH or -THRESH.
// On a hit the accumulator is cleared instead of taking the threshold value,
// so its magnitude never reaches THRESH.
// Ports:
//   clk     in  clock
//   rst     in  synchronous active-high reset
//   clear   in  force accumulator to 0 (loop not tracking)
//   count   in  accept the vote this cycle
//   up      in  vote: more delay
//   dn      in  vote: less delay
//   hit_pos out this vote reaches +THRESH (combinational)
//   hit_neg out this vote reaches -THRESH (combinational)
module cdr_vote_acc #(
   parameter int ACC_W  = 6,
   parameter int THRESH = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic count,
   input  logic up,
   input  logic dn,
   output logic hit_pos,
   output logic hit_neg
);

   if (THRESH < 1 || THRESH > (2 ** (ACC_W - 1)) - 1) begin : g_bad_thresh
      $error("cdr_vote_acc: THRESH out of range for ACC_W");
   end

   localparam logic signed [ACC_W-1:0] ONE   = ACC_W'(1);
   localparam logic signed [ACC_W-1:0] POS_T = ACC_W'(THRESH);
   localparam logic signed [ACC_W-1:0] NEG_T = ACC_W'(-THRESH);

   logic signed [ACC_W-1:0] acc_reg;
   logic signed [ACC_W-1:0] acc_next;

   // Conflicting or absent votes leave the accumulator unchanged.
   always_comb begin
      acc_next = acc_reg;
      if (up && !dn) begin
         acc_next = acc_reg + ONE;
      end else if (dn && !up) begin
         acc_next = acc_reg - ONE;
      end
   end

   assign hit_pos = count && (acc_next == POS_T);
   assign hit_neg = count && (acc_next == NEG_T);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         acc_reg <= '0;
      end else if (count) begin
         acc_reg <= (hit_pos || hit_neg) ? '0 : acc_next;
      end
   end

endmodule

// File: rtl/phase_shift_controller.sv
// phase_shift_controller
// Delay-line phase controller. Integrates phase-detector votes and, when the
// vote balance reaches +/-THRESH, issues a one-cycle shift command to the
// delay line, updates the tap mirror, and ignores votes for HOLDOFF cycles
// while the line settles. 'locked' reports LOCK_WIN quiet tracking cycles.
// Ports:
//   clk         in  clock, rising edge
//   rst         in  synchronous active-high reset
//   en          in  loop enable; 0 returns to IDLE (tap_idx kept)
//   up          in  vote: more delay
//   dn          in  vote: less delay
//   shift_left  out one-cycle pulse, tap +1 (mod 16)
//   shift_right out one-cycle pulse, tap -1 (mod 16)
//   tap_idx     out mirror of the selected delay-line tap
//   locked      out loop has been shift-free for LOCK_WIN tracking cycles
module phase_shift_controller
   import cdr_pkg::*;
#(
   parameter int ACC_W    = 6,
   parameter int THRESH   = 8,
   parameter int HOLDOFF  = 4,
   parameter int LOCK_WIN = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             dn,
   output logic             shift_left,
   output logic             shift_right,
   output logic [TAP_W-1:0] tap_idx,
   output logic             locked
);

   if (HOLDOFF < 1) begin : g_bad_holdoff
      $error("phase_shift_controller: HOLDOFF must be at least 1");
   end
   if (LOCK_WIN < 1) begin : g_bad_lock_win
      $error("phase_shift_controller: LOCK_WIN must be at least 1");
   end
   if (NUM_TAPS != 2 ** TAP_W) begin : g_bad_taps
      $error("phase_shift_controller: NUM_TAPS must equal 2**TAP_W");
   end

   localparam int HO_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
   localparam int Q_W  = $clog2(LOCK_WIN + 1);

   cdr_state_t       state_reg;
   logic [HO_W-1:0]  holdoff_cnt_reg;
   logic [Q_W-1:0]   quiet_reg;
   logic             shift_left_reg;
   logic             shift_right_reg;
   logic [TAP_W-1:0] tap_idx_reg;
   logic             locked_reg;

   logic tracking;
   logic hit_pos;
   logic hit_neg;

   // Votes only count while tracking with the loop enabled; everywhere else
   // the accumulator is held at zero.
   assign tracking = en && (state_reg == ST_TRACK);

   cdr_vote_acc #(
      .ACC_W  (ACC_W),
      .THRESH (THRESH)
   ) u_vote_acc (
      .clk     (clk),
      .rst     (rst),
      .clear   (!tracking),
      .count   (tracking),
      .up      (up),
      .dn      (dn),
      .hit_pos (hit_pos),
      .hit_neg (hit_neg)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= ST_IDLE;
         holdoff_cnt_reg <= '0;
         quiet_reg       <= '0;
         shift_left_reg  <= 1'b0;
         shift_right_reg <= 1'b0;
         tap_idx_reg     <= '0;
         locked_reg      <= 1'b0;
      end else if (!en) begin
         // tap_idx is deliberately kept: the delay line keeps its tap too.
         state_reg       <= ST_IDLE;
         holdoff_cnt_reg <= '0;
         quiet_reg       <= '0;
         shift_left_reg  <= 1'b0;
         shift_right_reg <= 1'b0;
         locked_reg      <= 1'b0;
      end else begin
         shift_left_reg  <= 1'b0;
         shift_right_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               state_reg  <= ST_TRACK;
               quiet_reg  <= '0;
               locked_reg <= 1'b0;
            end
            ST_TRACK: begin
               if (hit_pos || hit_neg) begin
                  shift_left_reg  <= hit_pos;
                  shift_right_reg <= hit_neg;
                  tap_idx_reg     <= hit_pos ? tap_idx_reg + TAP_W'(1)
                                             : tap_idx_reg - TAP_W'(1);
                  state_reg       <= ST_HOLDOFF;
                  // The pulse cycle is the first holdoff cycle.
                  holdoff_cnt_reg <= HO_W'(HOLDOFF - 1);
                  quiet_reg       <= '0;
                  locked_reg      <= 1'b0;
               end else if (quiet_reg != Q_W'(LOCK_WIN)) begin
                  quiet_reg  <= quiet_reg + Q_W'(1);
                  locked_reg <= (quiet_reg == Q_W'(LOCK_WIN - 1));
               end
            end
            ST_HOLDOFF: begin
               if (holdoff_cnt_reg == '0) begin
                  state_reg <= ST_TRACK;
               end else begin
                  holdoff_cnt_reg <= holdoff_cnt_reg - HO_W'(1);
               end
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign shift_left  = shift_left_reg;
   assign shift_right = shift_right_reg;
   assign tap_idx     = tap_idx_reg;
   assign locked      = locked_reg;

endmodule

// File: tb/tb_phase_shift_controller.sv
module tb_phase_shift_controller;
   import cdr_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en  = 1'b0;
   logic       up  = 1'b0;
   logic       dn  = 1'b0;
   logic       shift_left;
   logic       shift_right;
   logic [3:0] tap_idx;
   logic       locked;

   int errors = 0;
   int checks = 0;

   phase_shift_controller #(
      .ACC_W    (6),
      .THRESH   (8),
      .HOLDOFF  (4),
      .LOCK_WIN (64)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .up          (up),
      .dn          (dn),
      .shift_left  (shift_left),
      .shift_right (shift_right),
      .tap_idx     (tap_idx),
      .locked      (locked)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       en;
      logic       up;
      logic       dn;
      logic       sl;
      logic       sr;
      logic [3:0] tap;
      logic       lk;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic r, input logic e, input logic u,
                               input logic d, input logic sl, input logic sr,
                               input logic [3:0] tap, input logic lk);
      vec_t v;
      v.rst = r; v.en = e; v.up = u; v.dn = d;
      v.sl = sl; v.sr = sr; v.tap = tap; v.lk = lk;
      vecs.push_back(v);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs, then sample 1 time unit after the edge.
   task automatic step(input logic r, input logic e, input logic u, input logic d);
      rst = r; en = e; up = u; dn = d;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int t_pulse[$];
      int n_sr;
      int n_sl;
      int tap15_at_15;
      int tap_at_16;
      bit found;

      // ---- table: basic up shift, holdoff, up&dn neutrality, dn wrap ----
      add(1,0,0,0, 0,0,4'd0,0);                                 // reset
      add(0,1,0,0, 0,0,4'd0,0);                                 // IDLE->TRACK
      for (int i = 0; i < 7; i++) add(0,1,1,0, 0,0,4'd0,0);     // acc 1..7
      add(0,1,1,0, 1,0,4'd1,0);                                 // 8th up: pulse
      for (int i = 0; i < 4; i++) add(0,1,1,0, 0,0,4'd1,0);     // holdoff
      for (int i = 0; i < 3; i++) add(0,1,1,1, 0,0,4'd1,0);     // up&dn no-op
      for (int i = 0; i < 7; i++) add(0,1,1,0, 0,0,4'd1,0);     // acc 7
      add(0,1,1,1, 0,0,4'd1,0);                                 // still 7
      add(0,1,1,0, 1,0,4'd2,0);                                 // hits 8
      add(1,0,0,0, 0,0,4'd0,0);                                 // reset
      add(0,1,0,0, 0,0,4'd0,0);
      for (int i = 0; i < 7; i++) add(0,1,0,1, 0,0,4'd0,0);
      add(0,1,0,1, 0,1,4'd15,0);                                // wrap 0->15
      add(0,1,0,1, 0,0,4'd15,0);                                // one-cycle pulse
      add(0,0,0,0, 0,0,4'd15,0);                                // en drop in holdoff
      add(0,1,0,0, 0,0,4'd15,0);                                // back to TRACK
      for (int i = 0; i < 7; i++) add(0,1,0,1, 0,0,4'd15,0);
      add(0,1,0,1, 0,1,4'd14,0);

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].rst, vecs[i].en, vecs[i].up, vecs[i].dn);
         chk($sformatf("vec%0d {sl,sr,tap,lk}", i),
             int'({shift_left, shift_right, tap_idx, locked}),
             int'({vecs[i].sl, vecs[i].sr, vecs[i].tap, vecs[i].lk}));
         $display("vec %0d: rst=%0b en=%0b up=%0b dn=%0b -> sl=%0b sr=%0b tap=%0d lk=%0b",
                  i, vecs[i].rst, vecs[i].en, vecs[i].up, vecs[i].dn,
                  shift_left, shift_right, tap_idx, locked);
      end

      // ---- continuous up votes: pulse spacing and 15->0 wrap ----
      step(1,0,0,0);
      step(0,1,0,0);
      n_sr = 0; tap15_at_15 = -1; tap_at_16 = -1;
      for (int c = 1; c <= 195; c++) begin
         step(0,1,1,0);
         if (shift_right) n_sr++;
         if (shift_left) begin
            t_pulse.push_back(c);
            if (t_pulse.size() == 15) tap15_at_15 = tap_idx;
            if (t_pulse.size() == 16) tap_at_16 = tap_idx;
         end
      end
      chk("cont_pulse_count", t_pulse.size(), 16);
      if (t_pulse.size() > 0) chk("cont_first_pulse_cycle", t_pulse[0], 8);
      for (int i = 1; i < t_pulse.size(); i++)
         chk($sformatf("cont_gap%0d", i), t_pulse[i] - t_pulse[i-1], 12);
      chk("cont_tap_at_15th", tap15_at_15, 15);
      chk("cont_tap_at_16th", tap_at_16, 0);
      chk("cont_no_shift_right", n_sr, 0);
      $display("continuous up: %0d pulses, tap after 16th = %0d", t_pulse.size(), tap_at_16);

      // ---- quiet loop: lock after exactly 64 TRACK cycles ----
      step(1,0,0,0);
      step(0,1,0,0);
      n_sl = 0; n_sr = 0;
      for (int c = 1; c <= 200; c++) begin
         case (c % 4)
            0: step(0,1,1,0);
            1: step(0,1,0,1);
            2: step(0,1,1,1);
            default: step(0,1,0,0);
         endcase
         if (shift_left) n_sl++;
         if (shift_right) n_sr++;
         if (c == 63) chk("lock_not_yet_63", locked, 0);
         if (c == 64) chk("lock_at_64", locked, 1);
      end
      chk("quiet_no_sl", n_sl, 0);
      chk("quiet_no_sr", n_sr, 0);
      chk("lock_held_200", locked, 1);
      step(0,0,0,0);
      chk("lock_cleared_en0", locked, 0);
      $display("quiet loop: sl=%0d sr=%0d locked after en drop=%0b", n_sl, n_sr, locked);

      // ---- reset during holdoff / pulse cycle at tap 5 ----
      step(1,0,0,0);
      step(0,1,0,0);
      found = 1'b0;
      for (int c = 0; c < 100 && !found; c++) begin
         step(0,1,1,0);
         if (shift_left && tap_idx == 4'd5) found = 1'b1;
      end
      chk("reach_tap5", int'(found), 1);
      step(1,1,1,0);
      chk("rst_holdoff_outs", int'({shift_left, shift_right, tap_idx, locked}), 0);
      chk("rst_holdoff_state", int'(dut.state_reg), int'(ST_IDLE));
      $display("reset in holdoff: sl=%0b sr=%0b tap=%0d lk=%0b", shift_left, shift_right, tap_idx, locked);

      // ---- en dropped at acc=+7, then re-enable ----
      step(0,1,0,0);
      for (int i = 0; i < 8; i++) step(0,1,1,0);
      chk("en_drop_first_shift_tap", tap_idx, 1);
      for (int i = 0; i < 4; i++) step(0,1,0,0);
      for (int i = 0; i < 7; i++) step(0,1,1,0);
      chk("en_drop_acc_at_7", int'(dut.u_vote_acc.acc_reg), 7);
      step(0,0,1,0);
      chk("en_drop_state", int'(dut.state_reg), int'(ST_IDLE));
      chk("en_drop_acc", int'(dut.u_vote_acc.acc_reg), 0);
      chk("en_drop_tap", tap_idx, 1);
      chk("en_drop_sl", shift_left, 0);
      step(0,1,1,0);
      n_sl = 0;
      for (int i = 0; i < 7; i++) begin
         step(0,1,1,0);
         if (shift_left) n_sl++;
      end
      chk("reenable_no_early_pulse", n_sl, 0);
      step(0,1,1,0);
      chk("reenable_8th_pulse", shift_left, 1);
      chk("reenable_tap", tap_idx, 2);
      $display("en drop/re-enable: early pulses=%0d tap=%0d", n_sl, tap_idx);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Independent watchdog so the run always ends.
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   // Pulses must be mutually exclusive on every cycle.
   always @(negedge clk) begin
      if (shift_left && shift_right) begin
         errors++;
         $display("FAIL both_shifts: got sl=1 sr=1 expected at most one");
      end
   end

endmodule
